// File: rtl/fir_filter_tdm.sv
// Time-multiplexed FIR filter: one shared MAC, TAPS cycles per output sample,
// runtime-loadable coefficients, rounded/saturated output, valid/ready on both sides.
module fir_filter_tdm #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [OUT_W-1:0]  y,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_err,
  input  logic                     clear_hist
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam logic signed [EXT_W-1:0] RND_BIAS =
    (SHIFT > 0) ? (EXT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state_reg, state_next;
  logic signed [DATA_W-1:0]  hist_reg [TAPS];
  logic signed [COEF_W-1:0]  coef_reg [TAPS];
  logic [AW-1:0]             wptr_reg, rd_idx_reg, k_reg;
  logic signed [ACC_W-1:0]   acc_reg, acc_sum, prod_ext;
  logic signed [OUT_W-1:0]   y_reg, sat_val;
  logic                      coef_err_reg;

  logic                      idle, accept, coef_ok, k_last;
  logic [AW-1:0]             wptr_eff, wptr_inc;
  logic [TAPS-1:0]           hist_hit, coef_hit;
  logic signed [PROD_W-1:0]  prod;
  logic signed [EXT_W-1:0]   acc_ext, rnd;

  assign idle     = (state_reg == IDLE);
  assign accept   = idle && in_valid;
  assign coef_ok  = idle && coef_we && ({1'b0, coef_addr} < (AW+1)'(TAPS));
  // A clear in the accept cycle restarts the history at slot 0 before x is stored.
  assign wptr_eff = clear_hist ? '0 : wptr_reg;
  assign wptr_inc = (wptr_eff == LAST) ? '0 : wptr_eff + 1'b1;
  assign k_last   = (k_reg == LAST);

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      assign hist_hit[gi] = accept && (wptr_eff == AW'(gi));
      assign coef_hit[gi] = coef_ok && (coef_addr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        hist_reg[i] <= '0;
        coef_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (hist_hit[i])
          hist_reg[i] <= x;
        else if (idle && clear_hist)
          hist_reg[i] <= '0;
        if (coef_hit[i])
          coef_reg[i] <= coef_wdata;
      end
    end
  end

  // Shared multiply-accumulate; the sum of the final MAC cycle feeds rounding directly.
  assign prod     = coef_reg[k_reg] * hist_reg[rd_idx_reg];
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_sum  = acc_reg + prod_ext;
  assign acc_ext  = {{(EXT_W-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
  assign rnd      = (acc_ext + RND_BIAS) >>> SHIFT;

  always_comb begin
    sat_val = rnd[OUT_W-1:0];
    if (rnd > OUT_MAX)
      sat_val = OUT_MAX[OUT_W-1:0];
    else if (rnd < OUT_MIN)
      sat_val = OUT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wptr_reg     <= '0;
      rd_idx_reg   <= '0;
      k_reg        <= '0;
      acc_reg      <= '0;
      y_reg        <= '0;
      coef_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      coef_err_reg <= coef_we && !coef_ok;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            wptr_reg   <= wptr_inc;
            rd_idx_reg <= wptr_eff;
            k_reg      <= '0;
            acc_reg    <= '0;
          end else if (clear_hist) begin
            wptr_reg <= '0;
          end
        end
        MAC: begin
          acc_reg    <= acc_sum;
          k_reg      <= k_reg + 1'b1;
          rd_idx_reg <= (rd_idx_reg == '0) ? LAST : rd_idx_reg - 1'b1;
          if (k_last)
            y_reg <= sat_val;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = MAC;
      end
      MAC: begin
        if (k_last)
          state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign y        = y_reg;
  assign coef_err = coef_err_reg;

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Scoreboard bench for fir_filter_tdm: dut_a runs with SHIFT=0, dut_b with SHIFT=2
// for the rounding vectors. Expected outputs are queued at issue, popped by a monitor.
module tb_fir_filter_tdm;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int TAPS = 8;
  localparam int OW   = 16;
  localparam int AW   = $clog2(TAPS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic signed [DW-1:0] a_x, b_x;
  logic                 a_in_valid, b_in_valid, a_in_ready, b_in_ready;
  logic signed [OW-1:0] a_y, b_y;
  logic                 a_out_valid, b_out_valid, a_out_ready, b_out_ready;
  logic                 a_coef_we, b_coef_we;
  logic [AW-1:0]        a_coef_addr, b_coef_addr;
  logic signed [CW-1:0] a_coef_wdata, b_coef_wdata;
  logic                 a_coef_err, b_coef_err, a_clear, b_clear;

  int exp_a[$];
  int exp_b[$];
  int n_vec = 0;
  int n_err = 0;

  fir_filter_tdm #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .OUT_W(OW), .SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .x(a_x), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .y(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready), .coef_we(a_coef_we),
    .coef_addr(a_coef_addr), .coef_wdata(a_coef_wdata), .coef_err(a_coef_err),
    .clear_hist(a_clear)
  );

  fir_filter_tdm #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .OUT_W(OW), .SHIFT(2)) dut_b (
    .clk(clk), .reset(reset), .x(b_x), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .y(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready), .coef_we(b_coef_we),
    .coef_addr(b_coef_addr), .coef_wdata(b_coef_wdata), .coef_err(b_coef_err),
    .clear_hist(b_clear)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_of(input bit b);
    return b ? b_in_ready : a_in_ready;
  endfunction

  task automatic wait_idle(input bit b);
    int n = 0;
    while (!ready_of(b) && n < 100) begin
      tick();
      n++;
    end
    if (!ready_of(b)) timeout("wait_idle");
  endtask

  task automatic send(input bit b, input int v, input bit push, input int exp);
    wait_idle(b);
    if (push) begin
      if (b) exp_b.push_back(exp);
      else   exp_a.push_back(exp);
    end
    if (b) begin b_x = DW'(v); b_in_valid = 1'b1; end
    else   begin a_x = DW'(v); a_in_valid = 1'b1; end
    tick();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic wcoef(input bit b, input int addr, input int val, input int exp_err, input string name);
    if (b) begin b_coef_we = 1'b1; b_coef_addr = AW'(addr); b_coef_wdata = CW'(val); end
    else   begin a_coef_we = 1'b1; a_coef_addr = AW'(addr); a_coef_wdata = CW'(val); end
    tick();
    a_coef_we = 1'b0;
    b_coef_we = 1'b0;
    check(name, b ? b_coef_err : a_coef_err, exp_err);
  endtask

  task automatic clear(input bit b);
    wait_idle(b);
    if (b) b_clear = 1'b1;
    else   a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    b_clear = 1'b0;
  endtask

  task automatic wait_out_a(input string name, output int n);
    n = 0;
    while (!a_out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!a_out_valid) timeout(name);
  endtask

  // Monitor: one pop per accepted output beat.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_unexpected: y=%0d with no expected value queued", a_y);
        end else check("a_y", a_y, exp_a.pop_front());
      end
      if (b_out_valid && b_out_ready) begin
        if (exp_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_unexpected: y=%0d with no expected value queued", b_y);
        end else check("b_y", b_y, exp_b.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ramp_exp [5] = '{1, 3, 6, 10, 15};
    int sat_pos  [8] = '{16129, 32258, 32767, 32767, 32767, 32767, 32767, 32767};
    int sat_neg  [8] = '{32767, 32767, 31877, -508, -32768, -32768, -32768, -32768};
    int rnd_x    [6] = '{6, -6, 5, -7, 7, 127};
    int rnd_exp  [6] = '{2, -1, 1, -2, 2, 32};

    reset = 1'b1;
    a_x = '0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_coef_we = 1'b0;
    a_coef_addr = '0; a_coef_wdata = '0; a_clear = 1'b0;
    b_x = '0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_coef_we = 1'b0;
    b_coef_addr = '0; b_coef_wdata = '0; b_clear = 1'b0;
    repeat (3) tick();
    check("rst_y", a_y, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_coef_err", a_coef_err, 0);
    reset = 1'b0;
    tick();

    // Impulse through coef[k]=k+1
    for (int k = 0; k < TAPS; k++) wcoef(0, k, k + 1, 0, "imp_coef_err");
    for (int i = 0; i < 9; i++) send(0, (i == 0) ? 1 : 0, 1, (i < 8) ? i + 1 : 0);

    // Ramp with unit coefficients, plus latency from accept to out_valid
    wait_idle(0);
    for (int k = 0; k < TAPS; k++) wcoef(0, k, 1, 0, "ramp_coef_err");
    clear(0);
    for (int i = 0; i < 5; i++) begin
      send(0, i + 1, 1, ramp_exp[i]);
      wait_out_a("ramp_latency_wait", n);
      check("ramp_latency", n, TAPS);
    end

    // Saturation at both rails
    wait_idle(0);
    for (int k = 0; k < TAPS; k++) wcoef(0, k, 127, 0, "sat_coef_err");
    clear(0);
    for (int i = 0; i < 8; i++) send(0, 127, 1, sat_pos[i]);
    for (int i = 0; i < 8; i++) send(0, -128, 1, sat_neg[i]);

    // Rounding on the SHIFT=2 instance
    wait_idle(1);
    wcoef(1, 0, 1, 0, "rnd_coef_err");
    for (int i = 0; i < 6; i++) send(1, rnd_x[i], 1, rnd_exp[i]);

    // Backpressure: output held while out_ready is low
    clear(0);
    a_out_ready = 1'b0;
    send(0, 1, 1, 127);
    wait_out_a("stall_wait", n);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", a_out_valid, 1);
      check("stall_y", a_y, 127);
      check("stall_in_ready", a_in_ready, 0);
      tick();
    end
    a_out_ready = 1'b1;
    tick();
    check("release_out_valid", a_out_valid, 0);
    check("release_in_ready", a_in_ready, 1);

    // Coefficient write during MAC is dropped
    clear(0);
    send(0, 1, 1, 127);
    wcoef(0, 0, 5, 1, "mac_coef_err");
    tick();
    check("coef_err_pulse_end", a_coef_err, 0);
    clear(0);
    send(0, 1, 1, 127);

    // Reset in the middle of MAC aborts the sample
    wait_idle(0);
    wait_idle(1);
    send(0, 1, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_y", a_y, 0);
    check("abort_out_valid", a_out_valid, 0);
    check("abort_in_ready", a_in_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    send(0, 1, 1, 0);
    send(0, 0, 1, 0);
    send(0, 0, 1, 0);

    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    if (exp_a.size() != 0 || exp_b.size() != 0) timeout("drain");
    repeat (20) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
